// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory / load-store unit:
// RV32I funct3 load/store codes, clear-sequencer states and lane helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_t;

  // Byte lanes touched by a store of the given size at byte offset off.
  // Halfwords use off[1] only and words use no offset bits, so an unaligned
  // address is forced down to its natural boundary.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    lane_mask = 4'b0001 << off;
      F3_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Store data replicated across lanes so any selected lane sees its bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    store_data = {4{wd[7:0]}};
      F3_H:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Natural-alignment violation for a load of the given size.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: load_misaligned = off[0];
      F3_W:        load_misaligned = |off;
      default:     load_misaligned = 1'b0;
    endcase
  endfunction

  // Natural-alignment violation for a store of the given size.
  function automatic logic store_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H:    store_misaligned = off[0];
      F3_W:    store_misaligned = |off;
      default: store_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rd
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Extract the addressed lanes, then extend per access type.
  always_comb begin
    shifted = word >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    rd = {{24{byte_v[7]}}, byte_v};
      F3_H:    rd = {{16{half_v[15]}}, half_v};
      F3_W:    rd = word;
      F3_BU:   rd = {24'b0, byte_v};
      F3_HU:   rd = {16'b0, half_v};
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable little-endian data memory with RV32I load/store decode,
// a one-word-per-cycle clear sequencer and an optional alignment checker.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misalignment detection,
// suppression of misaligned accesses and a sticky fault flag).
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        busy,
  output logic        misaligned,
  output logic        fault
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  dmem_state_t   state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic [31:0]   rd_ext;
  logic          we;
  logic [AW-1:0] widx;
  logic [31:0]   wdata;
  logic [3:0]    wmask;
  logic          unused_addr;

  assign word_idx    = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign busy        = (state == CLEAR);
  assign rword       = mem[word_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = !busy &&
                      ((mem_read  && load_misaligned(funct3, addr[1:0])) ||
                       (mem_write && store_misaligned(funct3, addr[1:0])));

  // Sticky fault: set by any misaligned access, cleared by clear or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          fault <= 1'b0;
    else if (clear)      fault <= 1'b0;
    else if (misaligned) fault <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Clear sequencer: reset or clear restarts at word 0; leaves after the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (clear) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) state <= IDLE;
    end
  end

  // Write port arbitration: the clear sequence owns the port while busy;
  // a store coinciding with clear is dropped.
  always_comb begin
    we    = 1'b0;
    widx  = word_idx;
    wdata = store_data(funct3, wd);
    wmask = lane_mask(funct3, addr[1:0]);
    if (busy) begin
      we    = 1'b1;
      widx  = clr_idx;
      wdata = '0;
      wmask = 4'b1111;
    end else if (mem_write && !clear && !misaligned) begin
      we = 1'b1;
    end
  end

  // Byte-lane write into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  dmem_load_align u_load_align (
    .word   (rword),
    .off    (addr[1:0]),
    .funct3 (funct3),
    .rd     (rd_ext)
  );

  assign rd = (busy || !mem_read || misaligned) ? '0 : rd_ext;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu (DEPTH_WORDS=16): directed cases
// plus randomized accesses compared against a byte-array reference model.
module tb_data_memory_lsu;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NBYTES = 4 * DEPTH;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        busy;
  logic        misaligned;
  logic        fault;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  int unsigned m [NBYTES];
  bit          fault_m = 1'b0;

  data_memory_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .funct3     (funct3),
    .addr       (addr),
    .wd         (wd),
    .rd         (rd),
    .busy       (busy),
    .misaligned (misaligned),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ld_mis(input logic [2:0] f3, input logic [31:0] a);
    return TRAP && (((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0)));
  endfunction

  function automatic bit st_mis(input logic [2:0] f3, input logic [31:0] a);
    return TRAP && ((f3 == 3'd1 && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0)));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned i, v;
    v = 0;
    case (f3)
      3'd0, 3'd4: begin
        i = a % NBYTES;
        v = m[i];
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        i = (a - a % 2) % NBYTES;
        v = m[i] + 256 * m[i+1];
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      3'd2: begin
        i = (a - a % 4) % NBYTES;
        v = m[i] + 256 * m[i+1] + 65536 * m[i+2] + 16777216 * m[i+3];
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned i;
    case (f3)
      3'd0: m[a % NBYTES] = d % 256;
      3'd1: begin
        i = (a - a % 2) % NBYTES;
        m[i]   = d % 256;
        m[i+1] = (d / 256) % 256;
      end
      3'd2: begin
        i = (a - a % 4) % NBYTES;
        for (int k = 0; k < 4; k++) m[i+k] = (d >> (8 * k)) % 256;
      end
      default: ;
    endcase
  endtask

  task automatic m_zero();
    for (int i = 0; i < NBYTES; i++) m[i] = 0;
  endtask

  // One access: drive at posedge+1, check combinational outputs, commit on edge.
  task automatic access(input bit r, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    bit          exp_mis;
    mem_read  = r;
    mem_write = w;
    funct3    = f3;
    addr      = a;
    wd        = d;
    #2;
    exp_mis = (r && ld_mis(f3, a)) || (w && st_mis(f3, a));
    exp_rd  = (!r || exp_mis) ? 32'h0 : m_load(f3, a);
    got = rd;
    check("rd", rd, exp_rd);
    check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
    @(posedge clk);
    #1;
    if (w && !exp_mis) m_store(f3, a, d);
    if (exp_mis) fault_m = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("fault", {31'b0, fault}, {31'b0, fault_m});
  endtask

  // Count edges until busy drops, hammering ignored stores meanwhile.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      mem_read  = 1'b1;
      mem_write = 1'b1;
      funct3    = 3'd2;
      addr      = $urandom;
      wd        = $urandom;
      #2;
      check("busy_rd", rd, 32'h0);
      check("busy_mis", {31'b0, misaligned}, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("busy_edges", n, DEPTH);
    check("busy_fall", {31'b0, busy}, 32'h0);
  endtask

  task automatic read_all_zero(input string tag);
    logic [31:0] got;
    for (int i = 0; i < int'(DEPTH); i++) begin
      access(1'b1, 1'b0, 3'd2, 32'(4 * i), 32'h0, got);
      check(tag, got, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] got;
    int          n;

    // Reset state.
    mem_read = 1'b1;
    mem_write = 1'b1;
    #3;
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_mis", {31'b0, misaligned}, 32'h0);
    check("rst_rd", rd, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_idle(n);
    m_zero();
    fault_m = 1'b0;
    read_all_zero("init_zero");

    // Extension cases.
    access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
    access(1'b1, 1'b0, 3'd0, 32'h10, 32'h0, got); check("lb",  got, 32'hFFFFFFEF);
    access(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, got); check("lbu", got, 32'h000000DE);
    access(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, got); check("lh",  got, 32'hFFFFDEAD);
    access(1'b1, 1'b0, 3'd5, 32'h10, 32'h0, got); check("lhu", got, 32'h0000BEEF);

    // Lane merging.
    access(1'b0, 1'b1, 3'd2, 32'h20, 32'h11223344, got);
    access(1'b0, 1'b1, 3'd0, 32'h21, 32'h000000AA, got);
    access(1'b0, 1'b1, 3'd1, 32'h22, 32'h00005566, got);
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, got); check("merge", got, 32'h5566AA44);

    // Misaligned word store.
    access(1'b0, 1'b1, 3'd2, 32'h21, 32'h12345678, got);
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, got);
    check("mis_sw", got, TRAP ? 32'h5566AA44 : 32'h12345678);
    check("mis_fault", {31'b0, fault}, {31'b0, TRAP});

    // Read-during-write shows old contents, new data next cycle.
    access(1'b1, 1'b1, 3'd2, 32'h30, 32'hA5A5A5A5, got);
    access(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, got); check("rdw_new", got, 32'hA5A5A5A5);

    // Address wrap.
    access(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, got);
    access(1'b1, 1'b0, 3'd2, 32'h00, 32'h0, got); check("wrap", got, 32'hCAFEF00D);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
             $urandom, $urandom, got);
    end

    // Clear pulse with a simultaneous store.
    clear = 1'b1;
    mem_write = 1'b1;
    funct3 = 3'd2;
    addr = 32'h8;
    wd = 32'hFFFFFFFF;
    @(posedge clk); #1;
    clear = 1'b0;
    mem_write = 1'b0;
    fault_m = 1'b0;
    check("clr_busy", {31'b0, busy}, 32'h1);
    check("clr_fault", {31'b0, fault}, 32'h0);
    wait_idle(n);
    m_zero();
    read_all_zero("clr_zero");

    // Reset asserted during a store.
    access(1'b0, 1'b1, 3'd2, 32'h4, 32'h01020304, got);
    mem_write = 1'b1;
    funct3 = 3'd2;
    addr = 32'hC;
    wd = 32'h0BADF00D;
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    check("rst_hold_busy", {31'b0, busy}, 32'h1);
    mem_write = 1'b0;
    reset = 1'b1;
    wait_idle(n);
    m_zero();
    fault_m = 1'b0;
    read_all_zero("rst_zero");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
